// File: rtl/command_vars.sv
// Shared SPI NAND command encodings, feature-register bit positions and the
// state/status codes used by the operation sequencer.
package command_vars;

  typedef enum logic [7:0] {
    WRITE_ENABLE  = 8'h06,
    WRITE_DISABLE = 8'h04,
    GET_FEATURE   = 8'h0F,
    SET_FEATURE   = 8'h1F,
    PAGE_READ     = 8'h13,
    CACHE_READ    = 8'h03,
    PROG_LOAD1    = 8'h02,
    PROG_EXEC     = 8'h10,
    READ_ID       = 8'h9F,
    DEV_RESET     = 8'hFF
  } SPI_Command;

  // Bit positions inside the status feature register.
  localparam int OIP_BIT    = 0;
  localparam int WEL_BIT    = 1;
  localparam int P_FAIL_BIT = 3;
  localparam int ECC_MSB    = 5;
  localparam int ECC_LSB    = 4;

  localparam logic [1:0] ECC_UNCORRECTABLE = 2'b10;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_P_FAIL  = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [1:0] STATUS_ECC     = 2'b11;

  localparam logic OP_PROGRAM = 1'b0;
  localparam logic OP_READ    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT_RDY,
    ST_POLL_ISSUE,
    ST_POLL_GUARD,
    ST_POLL_WAIT,
    ST_DONE
  } seq_state_e;

  function automatic logic [23:0] col_to_addr(input logic [12:0] col);
    return {11'd0, col};
  endfunction

  function automatic logic [23:0] feature_to_addr(input logic [7:0] feat);
    return {8'd0, feat, 8'd0};
  endfunction

endpackage

// File: rtl/nand_op_sequencer.sv
// Sequences SPI NAND page program / page read operations as command steps
// handed to mem_command, polling the status feature register until complete.
module nand_op_sequencer
  import command_vars::*;
#(
  parameter int         MAX_POLLS = 1000,
  parameter logic [7:0] FEAT_ADDR = 8'hC0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Op_Req,
  input  logic        i_Op_Type,
  input  logic [23:0] i_Row_Addr,
  input  logic [12:0] i_Col_Addr,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [1:0]  o_Status,
  output SPI_Command  o_Command,
  output logic        o_CM_DV,
  output logic [23:0] o_Addr_Data,
  input  logic        i_CM_Ready,
  input  logic [7:0]  i_RX_Feature_Byte,
  input  logic        i_RX_Feature_DV
);

  localparam int                POLL_W     = $clog2(MAX_POLLS + 1);
  localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLLS);

  seq_state_e        state_q, state_d;
  logic              op_type_q, op_type_d;
  logic [23:0]       row_q, row_d;
  logic [12:0]       col_q, col_d;
  logic [1:0]        step_q, step_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]        feat_byte_q, feat_byte_d;
  logic              feat_valid_q, feat_valid_d;
  logic [1:0]        status_q, status_d;
  SPI_Command        command_q, command_d;
  logic [23:0]       addr_q, addr_d;
  logic              cm_dv;
  logic              start_poll;

  // Command and address are staged one state ahead so they are already
  // stable when the combinational valid pulse fires on i_CM_Ready.
  always_comb begin
    state_d      = state_q;
    op_type_d    = op_type_q;
    row_d        = row_q;
    col_d        = col_q;
    step_d       = step_q;
    poll_cnt_d   = poll_cnt_q;
    feat_byte_d  = feat_byte_q;
    feat_valid_d = feat_valid_q;
    status_d     = status_q;
    command_d    = command_q;
    addr_d       = addr_q;
    cm_dv        = 1'b0;
    start_poll   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_Op_Req) begin
          op_type_d    = i_Op_Type;
          row_d        = i_Row_Addr;
          col_d        = i_Col_Addr;
          step_d       = 2'd0;
          poll_cnt_d   = '0;
          feat_valid_d = 1'b0;
          status_d     = STATUS_OK;
          if (i_Op_Type == OP_READ) begin
            command_d = PAGE_READ;
            addr_d    = i_Row_Addr;
          end else begin
            command_d = WRITE_ENABLE;
            addr_d    = 24'd0;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (i_CM_Ready) begin
          cm_dv   = 1'b1;
          state_d = ST_GUARD;
        end
      end

      ST_GUARD: begin
        state_d = ST_WAIT_RDY;
      end

      ST_WAIT_RDY: begin
        if (i_CM_Ready) begin
          if (op_type_q == OP_PROGRAM) begin
            case (step_q)
              2'd0: begin
                step_d    = 2'd1;
                command_d = PROG_LOAD1;
                addr_d    = col_to_addr(col_q);
                state_d   = ST_ISSUE;
              end
              2'd1: begin
                step_d    = 2'd2;
                command_d = PROG_EXEC;
                addr_d    = row_q;
                state_d   = ST_ISSUE;
              end
              default: start_poll = 1'b1;
            endcase
          end else if (step_q == 2'd0) begin
            start_poll = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_POLL_ISSUE: begin
        if (i_CM_Ready) begin
          cm_dv      = 1'b1;
          poll_cnt_d = poll_cnt_q + POLL_W'(1);
          state_d    = ST_POLL_GUARD;
        end
      end

      ST_POLL_GUARD: begin
        state_d = ST_POLL_WAIT;
      end

      // The returned byte is captured first and judged on the following
      // cycle, so the decision always works from the latched copy.
      ST_POLL_WAIT: begin
        if (feat_valid_q) begin
          feat_valid_d = 1'b0;
          if (feat_byte_q[OIP_BIT]) begin
            if (poll_cnt_q >= POLL_LIMIT) begin
              status_d = STATUS_TIMEOUT;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_POLL_ISSUE;
            end
          end else if (op_type_q == OP_PROGRAM) begin
            status_d = feat_byte_q[P_FAIL_BIT] ? STATUS_P_FAIL : STATUS_OK;
            state_d  = ST_DONE;
          end else if (feat_byte_q[ECC_MSB:ECC_LSB] == ECC_UNCORRECTABLE) begin
            status_d = STATUS_ECC;
            state_d  = ST_DONE;
          end else begin
            step_d    = 2'd1;
            command_d = CACHE_READ;
            addr_d    = col_to_addr(col_q);
            state_d   = ST_ISSUE;
          end
        end else if (i_RX_Feature_DV) begin
          feat_byte_d  = i_RX_Feature_Byte;
          feat_valid_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_poll) begin
      command_d = GET_FEATURE;
      addr_d    = feature_to_addr(FEAT_ADDR);
      state_d   = ST_POLL_ISSUE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      op_type_q    <= OP_PROGRAM;
      row_q        <= 24'd0;
      col_q        <= 13'd0;
      step_q       <= 2'd0;
      poll_cnt_q   <= '0;
      feat_byte_q  <= 8'd0;
      feat_valid_q <= 1'b0;
      status_q     <= STATUS_OK;
      command_q    <= WRITE_ENABLE;
      addr_q       <= 24'd0;
    end else begin
      state_q      <= state_d;
      op_type_q    <= op_type_d;
      row_q        <= row_d;
      col_q        <= col_d;
      step_q       <= step_d;
      poll_cnt_q   <= poll_cnt_d;
      feat_byte_q  <= feat_byte_d;
      feat_valid_q <= feat_valid_d;
      status_q     <= status_d;
      command_q    <= command_d;
      addr_q       <= addr_d;
    end
  end

  // WEL and the reserved feature bits play no part in sequencing.
  logic unused_feat_bits;
  assign unused_feat_bits = ^{feat_byte_q[7:6], feat_byte_q[2], feat_byte_q[WEL_BIT]};

  assign o_Busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_Done      = (state_q == ST_DONE);
  assign o_Status    = status_q;
  assign o_Command   = command_q;
  assign o_CM_DV     = cm_dv;
  assign o_Addr_Data = addr_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer: a small mem_command / feature responder
// drives two instances (default and MAX_POLLS=4) through program, read and error cases.
module tb_nand_op_sequencer;
  import command_vars::*;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        op_req0, op_req4;
  logic        op_type;
  logic [23:0] row_addr;
  logic [12:0] col_addr;
  logic        cm_ready;
  logic [7:0]  feat_byte;
  logic        feat_dv;

  logic        busy0, done0, dv0, busy4, done4, dv4;
  logic [1:0]  status0, status4;
  SPI_Command  cmd0, cmd4;
  logic [23:0] addr0, addr4;

  logic        sel = 1'b0;
  logic        mon_done, mon_dv;
  logic [1:0]  mon_status;
  SPI_Command  mon_cmd;
  logic [23:0] mon_addr;

  assign mon_done   = sel ? done4   : done0;
  assign mon_dv     = sel ? dv4     : dv0;
  assign mon_status = sel ? status4 : status0;
  assign mon_cmd    = sel ? cmd4    : cmd0;
  assign mon_addr   = sel ? addr4   : addr0;

  int checks = 0;
  int fails  = 0;

  SPI_Command  cmd_log[$];
  logic [23:0] addr_log[$];
  logic [7:0]  feat_script[$];
  int          done_cnt    = 0;
  int          dv_low_cnt  = 0;
  logic [1:0]  done_status = 2'b00;
  int          gap_cycles  = 2;
  int          gap_cnt     = 0;
  int          feat_delay  = 2;
  int          feat_cnt    = 0;
  bit          feat_pending = 1'b0;
  bit          issued      = 1'b0;
  bit          issued_gf   = 1'b0;

  nand_op_sequencer dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Op_Req(op_req0), .i_Op_Type(op_type),
    .i_Row_Addr(row_addr), .i_Col_Addr(col_addr), .o_Busy(busy0), .o_Done(done0),
    .o_Status(status0), .o_Command(cmd0), .o_CM_DV(dv0), .o_Addr_Data(addr0),
    .i_CM_Ready(cm_ready), .i_RX_Feature_Byte(feat_byte), .i_RX_Feature_DV(feat_dv)
  );

  nand_op_sequencer #(.MAX_POLLS(4), .FEAT_ADDR(8'hC0)) dut4 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Op_Req(op_req4), .i_Op_Type(op_type),
    .i_Row_Addr(row_addr), .i_Col_Addr(col_addr), .o_Busy(busy4), .o_Done(done4),
    .o_Status(status4), .o_Command(cmd4), .o_CM_DV(dv4), .o_Addr_Data(addr4),
    .i_CM_Ready(cm_ready), .i_RX_Feature_Byte(feat_byte), .i_RX_Feature_DV(feat_dv)
  );

  initial forever #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Responder inputs change 1 time unit after the rising edge.
  initial begin
    cm_ready  = 1'b1;
    feat_dv   = 1'b0;
    feat_byte = 8'h00;
    forever begin
      @(posedge i_Clk);
      #1;
      feat_dv = 1'b0;
      if (feat_pending) begin
        if (feat_cnt == 0) begin
          feat_dv = 1'b1;
          if (feat_script.size() > 0) feat_byte = feat_script.pop_front();
          else feat_byte = 8'h01;
          feat_pending = 1'b0;
        end else begin
          feat_cnt--;
        end
      end
      if (issued_gf) begin
        feat_pending = 1'b1;
        feat_cnt     = feat_delay;
        issued_gf    = 1'b0;
      end
      if (issued) begin
        issued = 1'b0;
        if (gap_cycles > 0) begin
          cm_ready = 1'b0;
          gap_cnt  = gap_cycles;
        end
      end else if (gap_cnt > 0) begin
        gap_cnt--;
        if (gap_cnt == 0) cm_ready = 1'b1;
      end
    end
  end

  // Monitor samples on the falling edge, when inputs and outputs are settled.
  initial begin
    forever begin
      @(negedge i_Clk);
      if (mon_dv === 1'b1) begin
        if (cm_ready !== 1'b1) dv_low_cnt++;
        cmd_log.push_back(mon_cmd);
        addr_log.push_back(mon_addr);
        issued = 1'b1;
        if (mon_cmd == GET_FEATURE) issued_gf = 1'b1;
      end
      if (mon_done === 1'b1) begin
        done_cnt++;
        done_status = mon_status;
      end
    end
  end

  task automatic clear_logs();
    cmd_log.delete();
    addr_log.delete();
    done_cnt   = 0;
    dv_low_cnt = 0;
  endtask

  task automatic send_req(input bit which, input logic typ, input logic [23:0] row,
                          input logic [12:0] col);
    @(negedge i_Clk);
    op_type  = typ;
    row_addr = row;
    col_addr = col;
    if (which) op_req4 = 1'b1;
    else op_req0 = 1'b1;
    @(negedge i_Clk);
    op_req0 = 1'b0;
    op_req4 = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge i_Clk);
      #1;
      if (done_cnt > base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Clk);
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
    checks++; if (dv0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_cm_dv: got %b expected 0", dv0); end
    checks++; if (status0 !== 2'b00) begin fails++; $display("[TB] FAIL reset_status: got %b expected 00", status0); end
    checks++; if (cmd0 !== WRITE_ENABLE) begin fails++; $display("[TB] FAIL reset_command: got %h expected 06", cmd0); end
    checks++; if (addr0 !== 24'd0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 000000", addr0); end
    checks++; if (busy4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_dut4: got %b expected 0", busy4); end
    i_Rst = 1'b0;
    @(negedge i_Clk);
  endtask

  task automatic test_program_ok();
    SPI_Command  exp_cmd [6] = '{WRITE_ENABLE, PROG_LOAD1, PROG_EXEC, GET_FEATURE, GET_FEATURE, GET_FEATURE};
    logic [23:0] exp_addr[6] = '{24'h000000, 24'h000034, 24'h000040, 24'h00C000, 24'h00C000, 24'h00C000};
    bit to;
    clear_logs();
    sel = 1'b0;
    feat_script = '{8'h01, 8'h01, 8'h00};
    send_req(1'b0, OP_PROGRAM, 24'h000040, 13'h034);
    checks++; if (busy0 !== 1'b1) begin fails++; $display("[TB] FAIL prog_busy_after_req: got %b expected 1", busy0); end
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL prog_ok_done: got no o_Done expected one within 1000 cycles"); end
    repeat (5) @(negedge i_Clk);
    checks++; if (cmd_log.size() != 6) begin fails++; $display("[TB] FAIL prog_ok_cmd_count: got %0d expected 6", cmd_log.size()); end
    for (int i = 0; i < 6 && i < cmd_log.size(); i++) begin
      checks++; if (cmd_log[i] !== exp_cmd[i]) begin fails++; $display("[TB] FAIL prog_ok_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_cmd[i]); end
      if (i > 0) begin
        checks++; if (addr_log[i] !== exp_addr[i]) begin fails++; $display("[TB] FAIL prog_ok_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
      end
    end
    checks++; if (done_status !== 2'b00) begin fails++; $display("[TB] FAIL prog_ok_status: got %b expected 00", done_status); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL prog_ok_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_program_fail();
    bit to;
    clear_logs();
    feat_script = '{8'h08};
    send_req(1'b0, OP_PROGRAM, 24'h000123, 13'h001);
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL prog_fail_done: got no o_Done expected one"); end
    repeat (10) @(negedge i_Clk);
    checks++; if (done_status !== 2'b01) begin fails++; $display("[TB] FAIL prog_fail_status: got %b expected 01", done_status); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL prog_fail_done_count: got %0d expected 1", done_cnt); end
    checks++; if (cmd_log.size() != 4) begin fails++; $display("[TB] FAIL prog_fail_cmd_count: got %0d expected 4", cmd_log.size()); end
    checks++; if (status0 !== 2'b01) begin fails++; $display("[TB] FAIL prog_fail_status_hold: got %b expected 01", status0); end
  endtask

  task automatic test_read_ok();
    SPI_Command  exp_cmd [3] = '{PAGE_READ, GET_FEATURE, CACHE_READ};
    logic [23:0] exp_addr[3] = '{24'h000040, 24'h00C000, 24'h000834};
    bit to;
    clear_logs();
    feat_script = '{8'h00};
    send_req(1'b0, OP_READ, 24'h000040, 13'h834);
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL read_ok_done: got no o_Done expected one"); end
    repeat (5) @(negedge i_Clk);
    checks++; if (cmd_log.size() != 3) begin fails++; $display("[TB] FAIL read_ok_cmd_count: got %0d expected 3", cmd_log.size()); end
    for (int i = 0; i < 3 && i < cmd_log.size(); i++) begin
      checks++; if (cmd_log[i] !== exp_cmd[i]) begin fails++; $display("[TB] FAIL read_ok_cmd[%0d]: got %h expected %h", i, cmd_log[i], exp_cmd[i]); end
      checks++; if (addr_log[i] !== exp_addr[i]) begin fails++; $display("[TB] FAIL read_ok_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
    end
    checks++; if (done_status !== 2'b00) begin fails++; $display("[TB] FAIL read_ok_status: got %b expected 00", done_status); end
  endtask

  task automatic test_read_ecc();
    bit to;
    clear_logs();
    feat_script = '{8'h20};
    send_req(1'b0, OP_READ, 24'h000040, 13'h834);
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL read_ecc_done: got no o_Done expected one"); end
    repeat (10) @(negedge i_Clk);
    checks++; if (cmd_log.size() != 2) begin fails++; $display("[TB] FAIL read_ecc_cmd_count: got %0d expected 2 (no CACHE_READ)", cmd_log.size()); end
    checks++; if (done_status !== 2'b11) begin fails++; $display("[TB] FAIL read_ecc_status: got %b expected 11", done_status); end
    checks++; if (status0 !== 2'b11) begin fails++; $display("[TB] FAIL read_ecc_status_hold: got %b expected 11", status0); end
  endtask

  task automatic test_timeout();
    bit to;
    int gf;
    clear_logs();
    sel = 1'b1;
    feat_script.delete();
    send_req(1'b1, OP_READ, 24'h000040, 13'h000);
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL timeout_done: got no o_Done expected one"); end
    repeat (10) @(negedge i_Clk);
    gf = 0;
    foreach (cmd_log[i]) if (cmd_log[i] == GET_FEATURE) gf++;
    checks++; if (gf != 4) begin fails++; $display("[TB] FAIL timeout_poll_count: got %0d expected 4", gf); end
    checks++; if (cmd_log.size() != 5) begin fails++; $display("[TB] FAIL timeout_cmd_count: got %0d expected 5", cmd_log.size()); end
    checks++; if (done_status !== 2'b10) begin fails++; $display("[TB] FAIL timeout_status: got %b expected 10", done_status); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL timeout_other_idle: got %b expected 0", busy0); end
    sel = 1'b0;
  endtask

  task automatic test_slow_ready();
    bit to;
    clear_logs();
    gap_cycles  = 50;
    feat_script = '{8'h01, 8'h00};
    @(negedge i_Clk);
    cm_ready = 1'b0;
    gap_cnt  = 50;
    send_req(1'b0, OP_PROGRAM, 24'h000200, 13'h010);
    repeat (20) @(negedge i_Clk);
    op_type = OP_READ;
    op_req0 = 1'b1;
    @(negedge i_Clk);
    op_req0 = 1'b0;
    repeat (100) @(negedge i_Clk);
    op_req0 = 1'b1;
    @(negedge i_Clk);
    op_req0 = 1'b0;
    wait_done(0, 3000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL slow_done: got no o_Done expected one within 3000 cycles"); end
    repeat (10) @(negedge i_Clk);
    checks++; if (dv_low_cnt != 0) begin fails++; $display("[TB] FAIL slow_dv_while_not_ready: got %0d expected 0", dv_low_cnt); end
    checks++; if (cmd_log.size() != 5) begin fails++; $display("[TB] FAIL slow_cmd_count: got %0d expected 5", cmd_log.size()); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL slow_busy_req_ignored: got %0d done pulses expected 1", done_cnt); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL slow_idle_after: got busy %b expected 0", busy0); end
    checks++; if (done_status !== 2'b00) begin fails++; $display("[TB] FAIL slow_status: got %b expected 00", done_status); end
    gap_cycles = 2;
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    int n;
    clear_logs();
    feat_delay = 30;
    feat_script.delete();
    send_req(1'b0, OP_PROGRAM, 24'h000040, 13'h034);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge i_Clk);
      #1;
      if (cmd_log.size() >= 4) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL rst_mid_reach_poll: got %0d commands expected 4", cmd_log.size()); end
    repeat (5) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_done: got %b expected 0", done0); end
    checks++; if (dv0 !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_cm_dv: got %b expected 0", dv0); end
    checks++; if (status0 !== 2'b00) begin fails++; $display("[TB] FAIL rst_mid_status: got %b expected 00", status0); end
    checks++; if (cmd0 !== WRITE_ENABLE) begin fails++; $display("[TB] FAIL rst_mid_command: got %h expected 06", cmd0); end
    checks++; if (addr0 !== 24'd0) begin fails++; $display("[TB] FAIL rst_mid_addr: got %h expected 000000", addr0); end
    i_Rst = 1'b0;
    n = cmd_log.size();
    repeat (60) @(negedge i_Clk);
    checks++; if (done_cnt != 0) begin fails++; $display("[TB] FAIL rst_mid_no_done: got %0d expected 0", done_cnt); end
    checks++; if (cmd_log.size() != n) begin fails++; $display("[TB] FAIL rst_mid_no_cmds: got %0d expected %0d", cmd_log.size(), n); end
    feat_delay  = 2;
    feat_script = '{8'h00};
    send_req(1'b0, OP_PROGRAM, 24'h000100, 13'h001);
    wait_done(0, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL rst_mid_fresh_done: got no o_Done expected one"); end
    repeat (5) @(negedge i_Clk);
    checks++; if (done_status !== 2'b00) begin fails++; $display("[TB] FAIL rst_mid_fresh_status: got %b expected 00", done_status); end
    checks++; if (cmd_log.size() != n + 4) begin fails++; $display("[TB] FAIL rst_mid_fresh_cmds: got %0d expected %0d", cmd_log.size(), n + 4); end
  endtask

  task automatic test_back_to_back();
    bit to;
    bit seen;
    clear_logs();
    feat_script = '{8'h00, 8'h00};
    send_req(1'b0, OP_READ, 24'h000040, 13'h010);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_Clk);
      #1;
      if (done0 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL b2b_first_done: got no o_Done expected one"); end
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy_with_done: got %b expected 0", busy0); end
    op_type  = OP_PROGRAM;
    row_addr = 24'h000300;
    col_addr = 13'h002;
    op_req0  = 1'b1;
    @(negedge i_Clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_req_at_done_ignored: got busy %b expected 0", busy0); end
    @(negedge i_Clk);
    #1;
    checks++; if (busy0 !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept_next_cycle: got busy %b expected 1", busy0); end
    op_req0 = 1'b0;
    wait_done(1, 1000, to);
    checks++; if (to) begin fails++; $display("[TB] FAIL b2b_second_done: got no o_Done expected one"); end
    repeat (5) @(negedge i_Clk);
    checks++; if (done_cnt != 2) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (cmd_log.size() != 7) begin fails++; $display("[TB] FAIL b2b_cmd_count: got %0d expected 7", cmd_log.size()); end
    if (cmd_log.size() > 3) begin
      checks++; if (cmd_log[3] !== WRITE_ENABLE) begin fails++; $display("[TB] FAIL b2b_second_first_cmd: got %h expected 06", cmd_log[3]); end
    end
    checks++; if (done_status !== 2'b00) begin fails++; $display("[TB] FAIL b2b_status: got %b expected 00", done_status); end
  endtask

  initial begin
    i_Rst    = 1'b1;
    op_req0  = 1'b0;
    op_req4  = 1'b0;
    op_type  = 1'b0;
    row_addr = 24'd0;
    col_addr = 13'd0;
    $display("[TB] starting nand_op_sequencer bench");
    test_reset();
    test_program_ok();
    test_program_fail();
    test_read_ok();
    test_read_ecc();
    test_timeout();
    test_slow_ready();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nand_op_sequencer.md
NAND_OP_SEQUENCER -- requirements
Module: nand_op_sequencer

Interface
REQ-001 Parameter MAX_POLLS, default 1000: maximum GET_FEATURE polls per operation before timeout.
REQ-002 Parameter FEAT_ADDR, default 8'hC0: status feature register address.
REQ-003 i_Clk  input  1  the only clock; all logic samples on its rising edge.
REQ-004 i_Rst  input  1  reset, synchronous, active-high.
REQ-005 i_Op_Req  input  1  single-cycle operation request; sampled only while o_Busy=0.
REQ-006 i_Op_Type  input  1  0=page program, 1=page read.
REQ-007 i_Row_Addr  input  24  block/page address.
REQ-008 i_Col_Addr  input  13  cache column address.
REQ-009 o_Busy  output  1  high from accepted request until o_Done.
REQ-010 o_Done  output  1  single-cycle completion pulse.
REQ-011 o_Status  output  2  valid with o_Done: 00 OK, 01 P_FAIL, 10 timeout, 11 ECC uncorrectable.
REQ-012 o_Command  output  SPI_Command  command to mem_command.
REQ-013 o_CM_DV  output  1  single-cycle command-valid pulse.
REQ-014 o_Addr_Data  output  24  address/data for o_Command.
REQ-015 i_CM_Ready  input  1  mem_command ready for next command.
REQ-016 i_RX_Feature_Byte  input  8  returned feature byte.
REQ-017 i_RX_Feature_DV  input  1  i_RX_Feature_Byte valid pulse.

Function
REQ-018 States: IDLE, ISSUE, GUARD, WAIT_RDY, POLL_ISSUE, POLL_GUARD, POLL_WAIT, DONE.
REQ-019 Request latched (type, row, col) in IDLE when i_Op_Req=1; o_Busy=1 the next cycle; requests while busy ignored.
REQ-020 Program step list: WRITE_ENABLE, PROG_LOAD1 (addr[12:0]=col), PROG_EXEC (addr=row), poll.
REQ-021 Read step list: PAGE_READ (addr=row), poll, CACHE_READ (addr[12:0]=col), wait ready, DONE.
REQ-022 ISSUE: when i_CM_Ready=1, drive o_Command/o_Addr_Data and o_CM_DV=1 for exactly one cycle; else hold o_CM_DV=0.
REQ-023 GUARD: one cycle ignoring i_CM_Ready, then WAIT_RDY until i_CM_Ready=1, then next step.
REQ-024 POLL_ISSUE: GET_FEATURE, o_Addr_Data[15:8]=FEAT_ADDR, other bits 0; poll counter increments per issue.
REQ-025 POLL_WAIT: on i_RX_Feature_DV, latch byte; bit0 (OIP)=1 -> POLL_ISSUE after i_CM_Ready=1; OIP=0 -> evaluate.
REQ-026 Evaluate program: bit3 (P_FAIL)=1 -> status 01, else 00; go DONE.
REQ-027 Evaluate read: bits[5:4]=2'b10 -> status 11 and DONE without CACHE_READ; else continue to CACHE_READ.
REQ-028 Poll counter reaching MAX_POLLS with OIP still 1 -> status 10, DONE; counter width $clog2(MAX_POLLS+1).
REQ-029 DONE: o_Done=1 one cycle, o_Busy=0 same cycle, return to IDLE; o_Status holds until next accepted request.
REQ-030 i_RX_Feature_DV outside POLL_WAIT ignored; i_Op_Req coincident with o_Done ignored.
REQ-031 Back-to-back: new request accepted earliest one cycle after o_Done.

Reset
REQ-032 i_Rst=1 at any clock edge, including mid-sequence: state IDLE, o_Busy=0, o_Done=0, o_CM_DV=0, o_Status=00, o_Command=WRITE_ENABLE, o_Addr_Data=0, poll counter 0.
REQ-033 Reset mid-operation issues no further commands; no o_Done produced for the aborted operation.

Structure
REQ-034 SPI_Command enum and feature-bit positions (OIP=0, WEL=1, P_FAIL=3, ECC=[5:4]) SHALL live in shared package command_vars.
REQ-035 Single module; no sub-modules; poll counter inline.

Verification
REQ-036 Program req row=24'h000040, col=13'h034, model OIP=1 twice then 8'h00 -> commands WREN, PROG_LOAD1(034), PROG_EXEC(000040), 3x GET_FEATURE(C0), o_Status=00.
REQ-037 Program, final feature 8'h08 -> o_Status=01, one o_Done pulse.
REQ-038 Read row=24'h000040, col=13'h834, feature 8'h00 -> PAGE_READ, GET_FEATURE, CACHE_READ(834), o_Status=00; feature 8'h20 -> no CACHE_READ, o_Status=11.
REQ-039 MAX_POLLS=4, OIP stuck 1 -> exactly 4 GET_FEATURE, o_Status=10.
REQ-040 i_CM_Ready held low 50 cycles before each command -> o_CM_DV never asserted while ready=0; i_Op_Req during busy ignored.
REQ-041 i_Rst pulsed during POLL_WAIT -> all outputs at reset values next cycle, no o_Done, fresh request completes normally.
